// File: rtl/alu_station_pkg.sv
// ---------------------------------------------------------------------------
// alu_station_pkg
//   Shared constants for the ALU reservation station: default widths and
//   depth, plus the idle encodings driven onto the dispatch port. The
//   opcode, ROB-tag and data "zero" values mirror the machine-wide constant
//   set so that the ALU sees the same NOP/no-tag encoding as every other
//   unit.
// ---------------------------------------------------------------------------
package alu_station_pkg;

   localparam int RS_DEPTH  = 8;
   localparam int RS_DATA_W = 32;
   localparam int RS_ROB_W  = 4;
   localparam int RS_OP_W   = 6;

   localparam logic [RS_OP_W-1:0]   NOP       = '0;
   localparam logic [RS_ROB_W-1:0]  ZERO_ROB  = '0;
   localparam logic [RS_DATA_W-1:0] ZERO_DATA = '0;

endpackage : alu_station_pkg

// File: rtl/alu_station_pick.sv
// ---------------------------------------------------------------------------
// rs_pick_lowest
//   Fixed-priority picker: reports whether any request bit is set and the
//   index of the lowest set bit. Used by the reservation station both to
//   find a free slot for issue and to choose the op to dispatch.
//
// Ports
//   req    in   N       request vector, bit 0 has highest priority
//   found  out  1       at least one request bit set
//   idx    out  IDX_W   index of lowest set bit (0 when none set)
// ---------------------------------------------------------------------------
module rs_pick_lowest #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      found = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule : rs_pick_lowest

// File: rtl/alu_station.sv
// ---------------------------------------------------------------------------
// alu_station
//   Reservation station in front of the ALU. Holds renamed ops from issue,
//   snoops two CDB buses (CDB0 = ALU results, CDB1 = load results) for
//   missing operands, and dispatches at most one ready op per cycle.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   flush                      mispredict clear from the ROB
//   in_valid, in_op, in_rob_tag, in_pc, in_imm,
//   in_vj, in_vk, in_qj, in_qk issue request; q=0 means value present
//   cdb0_tag/data, cdb1_tag/data  result broadcasts; tag 0 = idle
//   full                       no free entry (registered)
//   alu_op, alu_rob_tag, alu_pc, alu_a, alu_b, alu_imm
//                              registered dispatch; NOP / tag 0 when idle
// ---------------------------------------------------------------------------
module alu_station
   import alu_station_pkg::*;
#(
   parameter int DEPTH  = RS_DEPTH,
   parameter int DATA_W = RS_DATA_W,
   parameter int ROB_W  = RS_ROB_W,
   parameter int OP_W   = RS_OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [ROB_W-1:0]  in_rob_tag,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_vj,
   input  logic [DATA_W-1:0] in_vk,
   input  logic [ROB_W-1:0]  in_qj,
   input  logic [ROB_W-1:0]  in_qk,
   input  logic [ROB_W-1:0]  cdb0_tag,
   input  logic [DATA_W-1:0] cdb0_data,
   input  logic [ROB_W-1:0]  cdb1_tag,
   input  logic [DATA_W-1:0] cdb1_data,
   output logic              full,
   output logic [OP_W-1:0]   alu_op,
   output logic [ROB_W-1:0]  alu_rob_tag,
   output logic [DATA_W-1:0] alu_pc,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_imm
);

   localparam int IDX_W = $clog2(DEPTH);

   // Entry storage
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [OP_W-1:0]   op_q  [DEPTH];
   logic [OP_W-1:0]   op_d  [DEPTH];
   logic [ROB_W-1:0]  tag_q [DEPTH];
   logic [ROB_W-1:0]  tag_d [DEPTH];
   logic [DATA_W-1:0] pc_q  [DEPTH];
   logic [DATA_W-1:0] pc_d  [DEPTH];
   logic [DATA_W-1:0] imm_q [DEPTH];
   logic [DATA_W-1:0] imm_d [DEPTH];
   logic [DATA_W-1:0] vj_q  [DEPTH];
   logic [DATA_W-1:0] vj_d  [DEPTH];
   logic [DATA_W-1:0] vk_q  [DEPTH];
   logic [DATA_W-1:0] vk_d  [DEPTH];
   logic [ROB_W-1:0]  qj_q  [DEPTH];
   logic [ROB_W-1:0]  qj_d  [DEPTH];
   logic [ROB_W-1:0]  qk_q  [DEPTH];
   logic [ROB_W-1:0]  qk_d  [DEPTH];

   logic full_q, full_d;

   // Dispatch registers
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [ROB_W-1:0]  alu_tag_q, alu_tag_d;
   logic [DATA_W-1:0] alu_pc_q, alu_pc_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] alu_imm_q, alu_imm_d;

   logic [DEPTH-1:0] ready_vec;
   logic             free_found, ready_found;
   logic [IDX_W-1:0] free_idx, ready_idx;

   // An entry is eligible for dispatch only from its registered state, so
   // an operand captured from a CDB this cycle is first usable next cycle.
   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      end
   end

   rs_pick_lowest #(.N(DEPTH), .IDX_W(IDX_W)) u_free_pick (
      .req   (~busy_q),
      .found (free_found),
      .idx   (free_idx)
   );

   rs_pick_lowest #(.N(DEPTH), .IDX_W(IDX_W)) u_ready_pick (
      .req   (ready_vec),
      .found (ready_found),
      .idx   (ready_idx)
   );

   // Next-state for entries and dispatch registers. Flush wins over every
   // other action; otherwise wakeup, dispatch and issue all happen in the
   // same cycle. Issue only targets a slot that was free before the edge,
   // so it never collides with the entry being dispatched or woken.
   always_comb begin
      busy_d    = busy_q;
      op_d      = op_q;
      tag_d     = tag_q;
      pc_d      = pc_q;
      imm_d     = imm_q;
      vj_d      = vj_q;
      vk_d      = vk_q;
      qj_d      = qj_q;
      qk_d      = qk_q;
      alu_op_d  = OP_W'(NOP);
      alu_tag_d = ROB_W'(ZERO_ROB);
      alu_pc_d  = alu_pc_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_imm_d = alu_imm_q;

      if (flush) begin
         busy_d = '0;
      end else begin
         // Operand wakeup; j and k may each match a different bus.
         for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i]) begin
               if (qj_q[i] != '0 && qj_q[i] == cdb0_tag) begin
                  vj_d[i] = cdb0_data;
                  qj_d[i] = '0;
               end else if (qj_q[i] != '0 && qj_q[i] == cdb1_tag) begin
                  vj_d[i] = cdb1_data;
                  qj_d[i] = '0;
               end
               if (qk_q[i] != '0 && qk_q[i] == cdb0_tag) begin
                  vk_d[i] = cdb0_data;
                  qk_d[i] = '0;
               end else if (qk_q[i] != '0 && qk_q[i] == cdb1_tag) begin
                  vk_d[i] = cdb1_data;
                  qk_d[i] = '0;
               end
            end
         end

         if (ready_found) begin
            alu_op_d          = op_q[ready_idx];
            alu_tag_d         = tag_q[ready_idx];
            alu_pc_d          = pc_q[ready_idx];
            alu_a_d           = vj_q[ready_idx];
            alu_b_d           = vk_q[ready_idx];
            alu_imm_d         = imm_q[ready_idx];
            busy_d[ready_idx] = 1'b0;
         end

         // Issue uses the registered full flag, so a slot freed by this
         // cycle's dispatch is not reused until next cycle.
         if (in_valid && !full_q && free_found) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = in_op;
            tag_d[free_idx]  = in_rob_tag;
            pc_d[free_idx]   = in_pc;
            imm_d[free_idx]  = in_imm;
            // Capture a producer broadcasting in the very cycle of issue.
            if (in_qj != '0 && in_qj == cdb0_tag) begin
               vj_d[free_idx] = cdb0_data;
               qj_d[free_idx] = '0;
            end else if (in_qj != '0 && in_qj == cdb1_tag) begin
               vj_d[free_idx] = cdb1_data;
               qj_d[free_idx] = '0;
            end else begin
               vj_d[free_idx] = in_vj;
               qj_d[free_idx] = in_qj;
            end
            if (in_qk != '0 && in_qk == cdb0_tag) begin
               vk_d[free_idx] = cdb0_data;
               qk_d[free_idx] = '0;
            end else if (in_qk != '0 && in_qk == cdb1_tag) begin
               vk_d[free_idx] = cdb1_data;
               qk_d[free_idx] = '0;
            end else begin
               vk_d[free_idx] = in_vk;
               qk_d[free_idx] = in_qk;
            end
         end
      end

      full_d = &busy_d;
   end

   // State registers; reset drops every entry and idles the dispatch port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         full_q    <= 1'b0;
         alu_op_q  <= OP_W'(NOP);
         alu_tag_q <= ROB_W'(ZERO_ROB);
         alu_pc_q  <= DATA_W'(ZERO_DATA);
         alu_a_q   <= DATA_W'(ZERO_DATA);
         alu_b_q   <= DATA_W'(ZERO_DATA);
         alu_imm_q <= DATA_W'(ZERO_DATA);
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= '0;
            tag_q[i] <= '0;
            pc_q[i]  <= '0;
            imm_q[i] <= '0;
            vj_q[i]  <= '0;
            vk_q[i]  <= '0;
            qj_q[i]  <= '0;
            qk_q[i]  <= '0;
         end
      end else begin
         busy_q    <= busy_d;
         full_q    <= full_d;
         alu_op_q  <= alu_op_d;
         alu_tag_q <= alu_tag_d;
         alu_pc_q  <= alu_pc_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_imm_q <= alu_imm_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         pc_q      <= pc_d;
         imm_q     <= imm_d;
         vj_q      <= vj_d;
         vk_q      <= vk_d;
         qj_q      <= qj_d;
         qk_q      <= qk_d;
      end
   end

   assign full        = full_q;
   assign alu_op      = alu_op_q;
   assign alu_rob_tag = alu_tag_q;
   assign alu_pc      = alu_pc_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_imm     = alu_imm_q;

endmodule : alu_station

// File: tb/tb_alu_station.sv
// ---------------------------------------------------------------------------
// tb_alu_station
//   Self-checking bench for the ALU reservation station. Expected dispatches
//   are pushed into a scoreboard queue as each op is issued and popped
//   whenever the station presents a non-NOP op.
// ---------------------------------------------------------------------------
module tb_alu_station;
   import alu_station_pkg::*;

   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;

   typedef struct {
      logic [5:0]  op;
      logic [3:0]  tag;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
   } disp_t;

   typedef struct {
      logic [5:0]  op;
      logic [3:0]  tag;
      logic [31:0] vj;
      logic [3:0]  qj;
      logic [31:0] vk;
      logic [3:0]  qk;
      logic [3:0]  c0t;
      logic [31:0] c0d;
      logic [3:0]  c1t;
      logic [31:0] c1d;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [5:0]  in_op;
   logic [3:0]  in_rob_tag;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic [31:0] in_vj;
   logic [31:0] in_vk;
   logic [3:0]  in_qj;
   logic [3:0]  in_qk;
   logic [3:0]  cdb0_tag;
   logic [31:0] cdb0_data;
   logic [3:0]  cdb1_tag;
   logic [31:0] cdb1_data;
   logic        full;
   logic [5:0]  alu_op;
   logic [3:0]  alu_rob_tag;
   logic [31:0] alu_pc;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_imm;

   int    checks = 0;
   int    errors = 0;
   disp_t sb[$];
   vec_t  vecs[5];

   alu_station dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_op       (in_op),
      .in_rob_tag  (in_rob_tag),
      .in_pc       (in_pc),
      .in_imm      (in_imm),
      .in_vj       (in_vj),
      .in_vk       (in_vk),
      .in_qj       (in_qj),
      .in_qk       (in_qk),
      .cdb0_tag    (cdb0_tag),
      .cdb0_data   (cdb0_data),
      .cdb1_tag    (cdb1_tag),
      .cdb1_data   (cdb1_data),
      .full        (full),
      .alu_op      (alu_op),
      .alu_rob_tag (alu_rob_tag),
      .alu_pc      (alu_pc),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_imm     (alu_imm)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Compare the dispatch port against the scoreboard head, or require idle.
   task automatic checkOutput();
      disp_t e;
      if (alu_op !== NOP) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_dispatch: got op=%0h tag=%0h required none", alu_op, alu_rob_tag);
         end else begin
            e = sb.pop_front();
            if (alu_op !== e.op || alu_rob_tag !== e.tag || alu_pc !== e.pc ||
                alu_a !== e.a || alu_b !== e.b || alu_imm !== e.imm) begin
               errors++;
               $display("[TB] FAIL dispatch: got op=%0h tag=%0h pc=%0h a=%0h b=%0h imm=%0h required op=%0h tag=%0h pc=%0h a=%0h b=%0h imm=%0h",
                        alu_op, alu_rob_tag, alu_pc, alu_a, alu_b, alu_imm,
                        e.op, e.tag, e.pc, e.a, e.b, e.imm);
            end
         end
      end else begin
         checkVal("idle_tag", 32'(alu_rob_tag), 32'(ZERO_ROB));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idleInputs();
      in_valid   = 1'b0;
      flush      = 1'b0;
      in_op      = 6'd0;
      in_rob_tag = 4'd0;
      in_pc      = 32'd0;
      in_imm     = 32'd0;
      in_vj      = 32'd0;
      in_vk      = 32'd0;
      in_qj      = 4'd0;
      in_qk      = 4'd0;
      cdb0_tag   = 4'd0;
      cdb0_data  = 32'd0;
      cdb1_tag   = 4'd0;
      cdb1_data  = 32'd0;
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [3:0] tag,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] vj, input logic [3:0] qj,
                                input logic [31:0] vk, input logic [3:0] qk);
      in_valid   = 1'b1;
      in_op      = op;
      in_rob_tag = tag;
      in_pc      = pc;
      in_imm     = imm;
      in_vj      = vj;
      in_qj      = qj;
      in_vk      = vk;
      in_qk      = qk;
   endtask

   task automatic setCdb(input logic [3:0] t0, input logic [31:0] d0,
                         input logic [3:0] t1, input logic [31:0] d1);
      cdb0_tag  = t0;
      cdb0_data = d0;
      cdb1_tag  = t1;
      cdb1_data = d1;
   endtask

   task automatic pushExp(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      disp_t e;
      e.op = op; e.tag = tag; e.pc = pc; e.a = a; e.b = b; e.imm = imm;
      sb.push_back(e);
   endtask

   // Issue eight ops all waiting on tag 1 in j; slots fill in index order.
   task automatic fillWaiting(input logic [31:0] pc_base, input bit expect_dispatch);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(OP_ADD, 4'(i + 2), pc_base + 32'(i * 4), 32'(i), 32'hBAD0, 4'd1,
                       32'(i * 3), 4'd0);
         if (expect_dispatch)
            pushExp(OP_ADD, 4'(i + 2), pc_base + 32'(i * 4), 32'h55, 32'(i * 3), 32'(i));
         tick();
         if (i == 6) checkVal("full_at_7", 32'(full), 32'd0);
      end
      idleInputs();
      checkVal("full_at_8", 32'(full), 32'd1);
   endtask

   initial begin
      vecs[0] = '{OP_ADD, 4'd3, 32'd5,   4'd0, 32'd7,          4'd0, 4'd0, 32'd0,      4'd0, 32'd0,      32'd5,          32'd7};
      vecs[1] = '{OP_SUB, 4'd4, 32'd1,   4'd0, 32'd0,          4'd6, 4'd6, 32'd9,      4'd0, 32'd0,      32'd1,          32'd9};
      vecs[2] = '{OP_ADD, 4'd5, 32'd0,   4'd7, 32'd3,          4'd0, 4'd0, 32'd0,      4'd7, 32'h20,     32'h20,         32'd3};
      vecs[3] = '{OP_SUB, 4'd6, 32'd0,   4'd2, 32'd0,          4'd9, 4'd2, 32'h111,    4'd9, 32'h222,    32'h111,        32'h222};
      vecs[4] = '{OP_ADD, 4'd7, 32'hFFFFFFFF, 4'd0, 32'h80000000, 4'd0, 4'd5, 32'hDEAD, 4'd8, 32'hBEEF, 32'hFFFFFFFF,   32'h80000000};

      idleInputs();
      rst_n = 1'b0;
      #12;
      checkVal("reset_op", 32'(alu_op), 32'(NOP));
      checkVal("reset_tag", 32'(alu_rob_tag), 32'd0);
      checkVal("reset_full", 32'(full), 32'd0);
      checkVal("reset_a", alu_a, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single ops: ready operands or operands captured at issue
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].op, vecs[v].tag, 32'h100 + 32'(v * 4), 32'(v * 17),
                       vecs[v].vj, vecs[v].qj, vecs[v].vk, vecs[v].qk);
         setCdb(vecs[v].c0t, vecs[v].c0d, vecs[v].c1t, vecs[v].c1d);
         pushExp(vecs[v].op, vecs[v].tag, 32'h100 + 32'(v * 4), vecs[v].exp_a, vecs[v].exp_b, 32'(v * 17));
         tick();
         checkVal("vec_pending", 32'(sb.size()), 32'd1);
         idleInputs();
         tick();
         checkVal("vec_dispatched", 32'(sb.size()), 32'd0);
      end

      // Wakeup from CDB1 two cycles after issue
      applyStimulus(OP_SUB, 4'd4, 32'h300, 32'h7, 32'hAA, 4'd2, 32'd3, 4'd0);
      pushExp(OP_SUB, 4'd4, 32'h300, 32'h10, 32'd3, 32'h7);
      tick();
      idleInputs();
      tick();
      checkVal("wait_pending", 32'(sb.size()), 32'd1);
      setCdb(4'd0, 32'd0, 4'd2, 32'h10);
      tick();
      checkVal("no_same_cycle_dispatch", 32'(sb.size()), 32'd1);
      idleInputs();
      tick();
      checkVal("wake_dispatched", 32'(sb.size()), 32'd0);

      // Fill, reject extra issue, drain in index order
      fillWaiting(32'h200, 1'b1);
      applyStimulus(OP_ADD, 4'd10, 32'h400, 32'd0, 32'd1, 4'd0, 32'd2, 4'd0);
      tick();
      checkVal("full_reject", 32'(full), 32'd1);
      idleInputs();
      setCdb(4'd1, 32'h55, 4'd0, 32'd0);
      tick();
      checkVal("drain_start", 32'(sb.size()), 32'd8);
      setCdb(4'd0, 32'd0, 4'd0, 32'd0);
      applyStimulus(OP_ADD, 4'd11, 32'h404, 32'd0, 32'd1, 4'd0, 32'd2, 4'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         idleInputs();
         checkVal("drain_count", 32'(sb.size()), 32'(7 - k));
      end
      tick();
      tick();
      checkVal("drain_full", 32'(full), 32'd0);

      // Flush with three waiting, one ready, and a simultaneous issue
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_ADD, 4'(i + 2), 32'h500, 32'd0, 32'd0, 4'd1, 32'd0, 4'd0);
         tick();
      end
      applyStimulus(OP_SUB, 4'd9, 32'h504, 32'd0, 32'd1, 4'd0, 32'd1, 4'd0);
      tick();
      applyStimulus(OP_ADD, 4'd12, 32'h508, 32'd0, 32'd1, 4'd0, 32'd1, 4'd0);
      flush = 1'b1;
      tick();
      checkVal("flush_op", 32'(alu_op), 32'(NOP));
      idleInputs();
      setCdb(4'd1, 32'h77, 4'd0, 32'd0);
      tick();
      idleInputs();
      tick();
      tick();
      checkVal("flush_full", 32'(full), 32'd0);

      // Reset right after a dispatch
      applyStimulus(OP_ADD, 4'd13, 32'h600, 32'h3, 32'h21, 4'd0, 32'h22, 4'd0);
      pushExp(OP_ADD, 4'd13, 32'h600, 32'h21, 32'h22, 32'h3);
      tick();
      idleInputs();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checkVal("rst_disp_op", 32'(alu_op), 32'(NOP));
      checkVal("rst_disp_tag", 32'(alu_rob_tag), 32'd0);
      checkVal("rst_disp_a", alu_a, 32'd0);
      rst_n = 1'b1;

      // Reset while full drops every entry
      fillWaiting(32'h700, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkVal("rst_full", 32'(full), 32'd0);
      checkVal("rst_full_op", 32'(alu_op), 32'(NOP));
      rst_n = 1'b1;
      setCdb(4'd1, 32'h99, 4'd0, 32'd0);
      tick();
      idleInputs();
      tick();
      tick();
      checkVal("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_station
